fetch_stage: RTL

- Instruction-fetch stage of the TinyRisc-V multicycle core. Sits directly upstream of the datapath/controller decode path.
- Owns the architectural PC and issues one instruction-memory read at a time.
- Presents the fetched word as ir, together with its PC, under a valid/ready handshake.
- Computes the next PC from the controller's pc_sel, br_taken and next_pc signals when the instruction is accepted.

---
 rtl/fetch_stage_if.sv | 34 +++
 rtl/fetch_stage.sv | 104 ++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port and fetched-instruction handshake
// shared by the fetch stage, the instruction memory and decode.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata,
    output ir,
    output ir_pc,
    output ir_valid,
    input  ir_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata,
    input  ir,
    input  ir_pc,
    input  ir_valid,
    output ir_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// TinyRisc-V fetch stage: owns the PC, issues one imem read
// at a time and hands the word to decode under valid/ready.
module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          SEL_PC_WIDTH = 2,
  parameter logic [31:0] NOP_INSN     = 32'h0000_0013
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    c_fetch_stall,
  input  logic [SEL_PC_WIDTH-1:0] c_pc_sel,
  input  logic                    c_br_taken,
  input  logic [31:0]             c_next_pc,
  fetch_stage_if.master           bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_VALID
  } state_t;

  localparam logic [SEL_PC_WIDTH-1:0] SEL_JUMP   =
    SEL_PC_WIDTH'(1);
  localparam logic [SEL_PC_WIDTH-1:0] SEL_BRANCH =
    SEL_PC_WIDTH'(2);
  localparam logic [SEL_PC_WIDTH-1:0] SEL_HOLD   =
    SEL_PC_WIDTH'(3);

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_req;
  logic [31:0] r_addr;
  logic [31:0] r_ir;
  logic [31:0] r_ir_pc;
  logic        r_ir_valid;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic [31:0] w_next_pc;

  // Targets are forced word-aligned; HOLD re-fetches the same PC
  always_comb begin
    w_pc_plus4 = r_pc + 32'd4;
    w_target   = c_next_pc & 32'hFFFF_FFFC;
    w_next_pc  = w_pc_plus4;
    unique case (1'b1)
      c_pc_sel == SEL_JUMP:
        w_next_pc = w_target;
      (c_pc_sel == SEL_BRANCH) && c_br_taken:
        w_next_pc = w_target;
      c_pc_sel == SEL_HOLD:
        w_next_pc = r_pc;
      default:
        w_next_pc = w_pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_ir       <= NOP_INSN;
      r_ir_pc    <= RESET_PC;
      r_ir_valid <= 1'b0;
    end else begin
      r_req <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!c_fetch_stall) begin
            r_req   <= 1'b1;
            r_addr  <= r_pc;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            r_ir       <= bus.imem_rdata;
            r_ir_pc    <= r_pc;
            r_ir_valid <= 1'b1;
            r_state    <= S_VALID;
          end
        end
        S_VALID: begin
          if (bus.ir_ready) begin
            r_ir_valid <= 1'b0;
            r_pc       <= w_next_pc;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.imem_req  = r_req;
  assign bus.imem_addr = r_addr;
  assign bus.ir        = r_ir;
  assign bus.ir_pc     = r_ir_pc;
  assign bus.ir_valid  = r_ir_valid;

endmodule
